load_line_seq: RTL and testbench
================================

LOAD_LINE_SEQ -- requirements
Module: load_line_seq

Interface
REQ-001 Parameter: HP_WD_BYTE, default 4, data-beat width in bytes; matches the downstream load-fetch stage.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 instr_valid_i  input  1  load instruction present.
REQ-005 instr_ready_o  output  1  sequencer can accept an instruction.
REQ-006 instr_ddr_port_id_i  input  2  DDR port of the transfer.
REQ-007 instr_ddr_addr_i  input  30  DDR byte offset of line 0.
REQ-008 instr_line_size_i  input  12  bytes per line.
REQ-009 instr_line_num_i  input  10  number of lines to load.
REQ-010 instr_bank_id_i  input  10  destination bank; [9:8]==0 selects the image base downstream.
REQ-011 ddr_port_id_o, ddr_addr_o, line_size_o, bank_id_o  output  2/30/12/10  latched instruction fields, held stable from accept until the next accept.
REQ-012 start_o  output  1  one-cycle pulse; issues line 0.
REQ-013 triger_o  output  1  one-cycle pulse; issues the next line at previous address + line size.
REQ-014 load_data_en_i  input  1  one returned data beat from the fetch stage.
REQ-015 busy_o  output  1  high whenever state != IDLE.
REQ-016 line_cnt_o  output  10  number of lines issued so far for the current instruction.
REQ-017 done_o  output  1  one-cycle pulse when the instruction completes.

Function
REQ-018 FSM states: IDLE, ISSUE, WAIT, DONE.
REQ-019 instr_ready_o shall be 1 exactly when the state is IDLE; accept = instr_valid_i & instr_ready_o.
REQ-020 On accept: latch all instruction fields; beats_per_line = ceil(line_size/HP_WD_BYTE), computed in 12 bits; line_cnt cleared to 0.
REQ-021 IDLE->DONE on accept when line_num==0 or line_size==0; no start_o or triger_o is produced for that instruction.
REQ-022 IDLE->ISSUE on any other accept.
REQ-023 ISSUE lasts exactly one cycle and then goes to WAIT.
REQ-024 In ISSUE, start_o=1 if line_cnt==0, otherwise triger_o=1.
REQ-025 In ISSUE, line_cnt increments by 1 and beat_cnt is cleared to 0.
REQ-026 First start_o is in the cycle after the accept edge (latency 1).
REQ-027 start_o and triger_o are never high together.
REQ-028 In WAIT, each load_data_en_i=1 cycle increments beat_cnt.
REQ-029 When a beat makes beat_cnt equal beats_per_line: next state is DONE if line_cnt==line_num, else ISSUE.
REQ-030 Consequence of REQ-029: the next triger_o is in the cycle after the last beat of the previous line.
REQ-031 load_data_en_i is ignored in IDLE, ISSUE and DONE; extra beats beyond beats_per_line cannot occur because the state has already left WAIT.
REQ-032 DONE: done_o=1 for one cycle, then IDLE; a new instruction can be accepted in the cycle after done_o.
REQ-033 instr_valid_i while busy is not accepted and has no effect; the instruction is held upstream until instr_ready_o=1.
REQ-034 No timeout: WAIT persists indefinitely without beats.

Reset
REQ-035 While rst=1: state=IDLE; start_o, triger_o, done_o, busy_o=0; instr_ready_o=0; line_cnt_o, beat_cnt and all latched outputs=0.
REQ-036 instr_ready_o=1 from the first cycle after rst deasserts.
REQ-037 rst mid-transfer (ISSUE or WAIT) aborts within one cycle with no done_o; beats arriving after reset are ignored.

Verification
REQ-038 addr=0x100, size=16, num=3, HP_WD_BYTE=4, 4 beats/line -> start_o at accept+1; triger_o one cycle after the 4th and 8th beats; done_o one cycle after the 12th beat; line_cnt_o=3.
REQ-039 size=10 -> beats_per_line=3; line 1 issued after the 3rd beat, not the 4th.
REQ-040 num=0 or size=0 -> done_o at accept+1; no start_o or triger_o.
REQ-041 instr_valid_i held high during busy -> the second instruction is accepted only in the cycle after done_o; latched fields stay unchanged until then.
REQ-042 rst asserted after 2 of 4 beats of line 0 -> all outputs 0 next cycle, no done_o; a fresh instruction then runs normally.
REQ-043 Beats sparse (en every 3rd cycle) and beats back-to-back -> identical pulse ordering and line count; no lost or double-counted beats.

Source files
------------

// File: rtl/load_line_seq_if.sv
// Instruction, fetch-feedback and status bundle between the load issuer and load_line_seq.
// The master side drives instructions and data beats; the slave side is the sequencer.
interface load_line_seq_if;
    logic        instr_valid_i;
    logic        instr_ready_o;
    logic [1:0]  instr_ddr_port_id_i;
    logic [29:0] instr_ddr_addr_i;
    logic [11:0] instr_line_size_i;
    logic [9:0]  instr_line_num_i;
    logic [9:0]  instr_bank_id_i;
    logic [1:0]  ddr_port_id_o;
    logic [29:0] ddr_addr_o;
    logic [11:0] line_size_o;
    logic [9:0]  bank_id_o;
    logic        start_o;
    logic        triger_o;
    logic        load_data_en_i;
    logic        busy_o;
    logic [9:0]  line_cnt_o;
    logic        done_o;

    modport slave (
        input  instr_valid_i, instr_ddr_port_id_i, instr_ddr_addr_i,
               instr_line_size_i, instr_line_num_i, instr_bank_id_i, load_data_en_i,
        output instr_ready_o, ddr_port_id_o, ddr_addr_o, line_size_o, bank_id_o,
               start_o, triger_o, busy_o, line_cnt_o, done_o
    );

    modport master (
        output instr_valid_i, instr_ddr_port_id_i, instr_ddr_addr_i,
               instr_line_size_i, instr_line_num_i, instr_bank_id_i, load_data_en_i,
        input  instr_ready_o, ddr_port_id_o, ddr_addr_o, line_size_o, bank_id_o,
               start_o, triger_o, busy_o, line_cnt_o, done_o
    );
endinterface

// File: rtl/load_line_seq.sv
// Line-by-line load sequencer: issues line 0 with start, each following line with triger
// once the previous line's data beats have all returned, then pulses done.
module load_line_seq #(
    parameter int HP_WD_BYTE = 4
) (
    input logic         clk,
    input logic         rst,
    load_line_seq_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  ddr_port_id;
    logic [29:0] ddr_addr;
    logic [11:0] line_size;
    logic [9:0]  bank_id;
    logic [9:0]  line_num;
    logic [9:0]  line_cnt;
    logic [11:0] beats_per_line;
    logic [11:0] beat_cnt;
    logic        accept;
    logic        beat_last;
    logic        ready;
    logic        busy;
    logic        start;
    logic        triger;
    logic        done;

    // Intermediate is one bit wider so a line size near 4095 cannot wrap before dividing.
    function automatic logic [11:0] ceil_beats(input logic [11:0] size);
        logic [12:0] sum;
        sum = {1'b0, size} + 13'(HP_WD_BYTE - 1);
        return 12'(sum / 13'(HP_WD_BYTE));
    endfunction

    assign accept    = bus.instr_valid_i & ready;
    assign beat_last = bus.load_data_en_i && ((beat_cnt + 12'd1) == beats_per_line);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        busy      = 1'b0;
        start     = 1'b0;
        triger    = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                ready = !rst;
                if (accept) begin
                    if (bus.instr_line_num_i == 10'd0 || bus.instr_line_size_i == 12'd0)
                        state_nxt = DONE;
                    else
                        state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                busy      = !rst;
                start     = !rst && (line_cnt == 10'd0);
                triger    = !rst && (line_cnt != 10'd0);
                state_nxt = WAIT;
            end
            WAIT: begin
                busy = !rst;
                if (beat_last)
                    state_nxt = (line_cnt == line_num) ? DONE : ISSUE;
            end
            DONE: begin
                busy      = !rst;
                done      = !rst;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Latched instruction fields and line/beat counters; all cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ddr_port_id    <= '0;
            ddr_addr       <= '0;
            line_size      <= '0;
            bank_id        <= '0;
            line_num       <= '0;
            beats_per_line <= '0;
            line_cnt       <= '0;
            beat_cnt       <= '0;
        end else begin
            if (accept) begin
                ddr_port_id    <= bus.instr_ddr_port_id_i;
                ddr_addr       <= bus.instr_ddr_addr_i;
                line_size      <= bus.instr_line_size_i;
                bank_id        <= bus.instr_bank_id_i;
                line_num       <= bus.instr_line_num_i;
                beats_per_line <= ceil_beats(bus.instr_line_size_i);
                line_cnt       <= '0;
                beat_cnt       <= '0;
            end
            if (state == ISSUE) begin
                line_cnt <= line_cnt + 10'd1;
                beat_cnt <= '0;
            end
            if (state == WAIT && bus.load_data_en_i)
                beat_cnt <= beat_cnt + 12'd1;
        end
    end

    assign bus.instr_ready_o = ready;
    assign bus.busy_o        = busy;
    assign bus.start_o       = start;
    assign bus.triger_o      = triger;
    assign bus.done_o        = done;
    assign bus.ddr_port_id_o = ddr_port_id;
    assign bus.ddr_addr_o    = ddr_addr;
    assign bus.line_size_o   = line_size;
    assign bus.bank_id_o     = bank_id;
    assign bus.line_cnt_o    = line_cnt;

endmodule

// File: tb/tb_load_line_seq.sv
// Directed bench for load_line_seq: reset, multi-line runs, rounding of beats per line,
// empty instructions, held-valid back-pressure, mid-transfer reset and beat spacing.
module tb_load_line_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   n_start = 0;
    int   n_trig = 0;
    int   n_done = 0;
    int   n_overlap = 0;

    load_line_seq_if bus ();

    load_line_seq #(.HP_WD_BYTE(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.start_o === 1'b1) n_start++;
        if (bus.triger_o === 1'b1) n_trig++;
        if (bus.done_o === 1'b1) n_done++;
        if (bus.start_o === 1'b1 && bus.triger_o === 1'b1) n_overlap++;
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic accept_instr(input logic [1:0] port, input logic [29:0] addr,
                                input logic [11:0] size, input logic [9:0] num,
                                input logic [9:0] bank);
        int k;
        bus.instr_ddr_port_id_i = port;
        bus.instr_ddr_addr_i    = addr;
        bus.instr_line_size_i   = size;
        bus.instr_line_num_i    = num;
        bus.instr_bank_id_i     = bank;
        bus.instr_valid_i       = 1'b1;
        k = 0;
        while (bus.instr_ready_o !== 1'b1 && k < 50) begin
            cycle();
            k++;
        end
        checks++;
        if (bus.instr_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL accept_ready_timeout got=%b exp=1", bus.instr_ready_o);
        end
        cycle();
        bus.instr_valid_i = 1'b0;
    endtask

    // Runs one complete instruction; beats spaced by 'gap' idle cycles within a line.
    task automatic run_instr(input string name, input logic [29:0] addr, input logic [11:0] size,
                             input int num, input int bpl, input int gap, input bit en_in_issue);
        int s0, t0, d0;
        s0 = n_start; t0 = n_trig; d0 = n_done;
        accept_instr(2'd1, addr, size, 10'(num), 10'h055);
        checks++;
        if (bus.start_o !== 1'b1 || bus.triger_o !== 1'b0) begin
            errors++;
            $display("FAIL %s_start got start=%b triger=%b exp start=1 triger=0", name, bus.start_o, bus.triger_o);
        end
        checks++;
        if (bus.ddr_addr_o !== addr || bus.line_size_o !== size || bus.bank_id_o !== 10'h055) begin
            errors++;
            $display("FAIL %s_latch got addr=%h size=%0d bank=%h exp addr=%h size=%0d bank=055",
                     name, bus.ddr_addr_o, bus.line_size_o, bus.bank_id_o, addr, size);
        end
        for (int l = 0; l < num; l++) begin
            bus.load_data_en_i = en_in_issue;
            cycle();
            bus.load_data_en_i = 1'b0;
            checks++;
            if (bus.line_cnt_o !== 10'(l + 1)) begin
                errors++;
                $display("FAIL %s_line_cnt got=%0d exp=%0d", name, bus.line_cnt_o, l + 1);
            end
            for (int b = 0; b < bpl; b++) begin
                bus.load_data_en_i = 1'b1;
                cycle();
                bus.load_data_en_i = 1'b0;
                if (b < bpl - 1) begin
                    checks++;
                    if (bus.start_o !== 1'b0 || bus.triger_o !== 1'b0 || bus.done_o !== 1'b0) begin
                        errors++;
                        $display("FAIL %s_early_pulse line=%0d beat=%0d got start=%b triger=%b done=%b exp 0/0/0",
                                 name, l, b, bus.start_o, bus.triger_o, bus.done_o);
                    end
                    for (int g = 0; g < gap; g++) cycle();
                end else if (l == num - 1) begin
                    checks++;
                    if (bus.done_o !== 1'b1 || bus.triger_o !== 1'b0 || bus.line_cnt_o !== 10'(num)) begin
                        errors++;
                        $display("FAIL %s_done got done=%b triger=%b line_cnt=%0d exp done=1 triger=0 line_cnt=%0d",
                                 name, bus.done_o, bus.triger_o, bus.line_cnt_o, num);
                    end
                end else begin
                    checks++;
                    if (bus.triger_o !== 1'b1 || bus.start_o !== 1'b0) begin
                        errors++;
                        $display("FAIL %s_triger line=%0d got triger=%b start=%b exp triger=1 start=0",
                                 name, l, bus.triger_o, bus.start_o);
                    end
                end
            end
        end
        cycle();
        checks++;
        if (bus.instr_ready_o !== 1'b1 || bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle got ready=%b busy=%b done=%b exp 1/0/0", name, bus.instr_ready_o, bus.busy_o, bus.done_o);
        end
        checks++;
        if (n_start - s0 != 1 || n_trig - t0 != num - 1 || n_done - d0 != 1) begin
            errors++;
            $display("FAIL %s_pulse_counts got start=%0d triger=%0d done=%0d exp 1/%0d/1",
                     name, n_start - s0, n_trig - t0, n_done - d0, num - 1);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.instr_valid_i = 1'b1;
        bus.instr_ddr_port_id_i = 2'd3;
        bus.instr_ddr_addr_i = 30'h123;
        bus.instr_line_size_i = 12'd16;
        bus.instr_line_num_i = 10'd2;
        bus.instr_bank_id_i = 10'h3ff;
        bus.load_data_en_i = 1'b1;
        repeat (3) cycle();
        checks++;
        if (bus.instr_ready_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.start_o !== 1'b0 ||
            bus.triger_o !== 1'b0 || bus.done_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl got ready=%b busy=%b start=%b triger=%b done=%b exp all 0",
                     bus.instr_ready_o, bus.busy_o, bus.start_o, bus.triger_o, bus.done_o);
        end
        checks++;
        if (bus.line_cnt_o !== 10'd0 || bus.ddr_addr_o !== 30'd0 || bus.bank_id_o !== 10'd0 ||
            bus.line_size_o !== 12'd0 || bus.ddr_port_id_o !== 2'd0) begin
            errors++;
            $display("FAIL reset_fields got line_cnt=%0d addr=%h bank=%h size=%0d port=%0d exp all 0",
                     bus.line_cnt_o, bus.ddr_addr_o, bus.bank_id_o, bus.line_size_o, bus.ddr_port_id_o);
        end
        bus.instr_valid_i = 1'b0;
        bus.load_data_en_i = 1'b0;
        rst = 1'b0;
        cycle();
        checks++;
        if (bus.instr_ready_o !== 1'b1 || bus.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got ready=%b busy=%b exp ready=1 busy=0", bus.instr_ready_o, bus.busy_o);
        end
    endtask

    task automatic test_empty(input string name, input logic [11:0] size, input logic [9:0] num);
        int s0, t0;
        s0 = n_start; t0 = n_trig;
        accept_instr(2'd0, 30'h40, size, num, 10'h001);
        checks++;
        if (bus.done_o !== 1'b1 || bus.start_o !== 1'b0 || bus.triger_o !== 1'b0 || bus.busy_o !== 1'b1) begin
            errors++;
            $display("FAIL %s_done got done=%b start=%b triger=%b busy=%b exp 1/0/0/1",
                     name, bus.done_o, bus.start_o, bus.triger_o, bus.busy_o);
        end
        cycle();
        checks++;
        if (bus.instr_ready_o !== 1'b1 || bus.done_o !== 1'b0 || n_start != s0 || n_trig != t0 ||
            bus.line_cnt_o !== 10'd0) begin
            errors++;
            $display("FAIL %s_after got ready=%b done=%b starts=%0d trigs=%0d line_cnt=%0d exp 1/0/0/0/0",
                     name, bus.instr_ready_o, bus.done_o, n_start - s0, n_trig - t0, bus.line_cnt_o);
        end
    endtask

    task automatic test_hold_valid();
        accept_instr(2'd2, 30'h200, 12'd4, 10'd1, 10'h001);
        bus.instr_ddr_port_id_i = 2'd3;
        bus.instr_ddr_addr_i    = 30'h300;
        bus.instr_line_size_i   = 12'd8;
        bus.instr_line_num_i    = 10'd1;
        bus.instr_bank_id_i     = 10'h002;
        bus.instr_valid_i       = 1'b1;
        checks++;
        if (bus.start_o !== 1'b1 || bus.ddr_addr_o !== 30'h200) begin
            errors++;
            $display("FAIL hold_first got start=%b addr=%h exp start=1 addr=200", bus.start_o, bus.ddr_addr_o);
        end
        cycle();
        bus.load_data_en_i = 1'b1;
        cycle();
        bus.load_data_en_i = 1'b0;
        checks++;
        if (bus.done_o !== 1'b1 || bus.instr_ready_o !== 1'b0 || bus.ddr_addr_o !== 30'h200 ||
            bus.line_size_o !== 12'd4) begin
            errors++;
            $display("FAIL hold_busy got done=%b ready=%b addr=%h size=%0d exp 1/0/200/4",
                     bus.done_o, bus.instr_ready_o, bus.ddr_addr_o, bus.line_size_o);
        end
        cycle();
        checks++;
        if (bus.instr_ready_o !== 1'b1 || bus.start_o !== 1'b0 || bus.ddr_addr_o !== 30'h200 ||
            bus.ddr_port_id_o !== 2'd2) begin
            errors++;
            $display("FAIL hold_idle got ready=%b start=%b addr=%h port=%0d exp 1/0/200/2",
                     bus.instr_ready_o, bus.start_o, bus.ddr_addr_o, bus.ddr_port_id_o);
        end
        cycle();
        bus.instr_valid_i = 1'b0;
        checks++;
        if (bus.start_o !== 1'b1 || bus.ddr_addr_o !== 30'h300 || bus.ddr_port_id_o !== 2'd3 ||
            bus.bank_id_o !== 10'h002 || bus.line_size_o !== 12'd8) begin
            errors++;
            $display("FAIL hold_second got start=%b addr=%h port=%0d bank=%h size=%0d exp 1/300/3/002/8",
                     bus.start_o, bus.ddr_addr_o, bus.ddr_port_id_o, bus.bank_id_o, bus.line_size_o);
        end
        cycle();
        bus.load_data_en_i = 1'b1;
        cycle();
        checks++;
        if (bus.done_o !== 1'b0 || bus.triger_o !== 1'b0) begin
            errors++;
            $display("FAIL hold_second_beat1 got done=%b triger=%b exp 0/0", bus.done_o, bus.triger_o);
        end
        cycle();
        bus.load_data_en_i = 1'b0;
        checks++;
        if (bus.done_o !== 1'b1) begin
            errors++;
            $display("FAIL hold_second_done got=%b exp=1", bus.done_o);
        end
        cycle();
    endtask

    task automatic test_reset_mid();
        int d0;
        d0 = n_done;
        accept_instr(2'd1, 30'h80, 12'd16, 10'd2, 10'h010);
        cycle();
        bus.load_data_en_i = 1'b1;
        repeat (2) cycle();
        rst = 1'b1;
        cycle();
        checks++;
        if (bus.start_o !== 1'b0 || bus.triger_o !== 1'b0 || bus.done_o !== 1'b0 || bus.busy_o !== 1'b0 ||
            bus.instr_ready_o !== 1'b0 || bus.line_cnt_o !== 10'd0 || bus.ddr_addr_o !== 30'd0 ||
            bus.bank_id_o !== 10'd0) begin
            errors++;
            $display("FAIL midrst_outputs got start=%b triger=%b done=%b busy=%b ready=%b cnt=%0d addr=%h bank=%h exp all 0",
                     bus.start_o, bus.triger_o, bus.done_o, bus.busy_o, bus.instr_ready_o,
                     bus.line_cnt_o, bus.ddr_addr_o, bus.bank_id_o);
        end
        rst = 1'b0;
        repeat (3) cycle();
        bus.load_data_en_i = 1'b0;
        checks++;
        if (bus.instr_ready_o !== 1'b1 || bus.busy_o !== 1'b0 || bus.line_cnt_o !== 10'd0 || n_done != d0) begin
            errors++;
            $display("FAIL midrst_after got ready=%b busy=%b cnt=%0d dones=%0d exp 1/0/0/0",
                     bus.instr_ready_o, bus.busy_o, bus.line_cnt_o, n_done - d0);
        end
    endtask

    initial begin
        bus.instr_valid_i = 1'b0;
        bus.instr_ddr_port_id_i = '0;
        bus.instr_ddr_addr_i = '0;
        bus.instr_line_size_i = '0;
        bus.instr_line_num_i = '0;
        bus.instr_bank_id_i = '0;
        bus.load_data_en_i = 1'b0;
        test_reset();
        run_instr("basic", 30'h100, 12'd16, 3, 4, 0, 1'b1);
        run_instr("round", 30'h104, 12'd10, 2, 3, 0, 1'b0);
        test_empty("num0", 12'd16, 10'd0);
        test_empty("size0", 12'd0, 10'd3);
        test_hold_valid();
        test_reset_mid();
        run_instr("after_rst", 30'h100, 12'd16, 3, 4, 0, 1'b0);
        run_instr("sparse", 30'h400, 12'd16, 3, 4, 2, 1'b1);
        run_instr("b2b_odd", 30'h500, 12'd5, 4, 2, 0, 1'b1);
        checks++;
        if (n_overlap != 0) begin
            errors++;
            $display("FAIL start_triger_overlap got=%0d exp=0", n_overlap);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
